dma_cmd_arbiter: RTL and testbench

Multi-channel command front end for `axi_dma_controller`. It accepts DMA commands from `NUM_CH` independent requesters, buffers each channel in its own FIFO, and issues them one at a time to the single controller command port in round-robin order. It tracks the in-flight command until the controller signals completion and returns a per-channel done pulse. It sits between requesters and the controller, replacing the single direct `cmd_*` connection in the DMA top level.

---
 rtl/dma_cmd_arbiter.sv | 150 +++++++++++++++
 tb/tb_dma_cmd_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_cmd_arbiter.sv
// Round-robin command front end: per-channel command FIFOs feed the single
// controller command port, one outstanding command at a time, with per-channel done pulses.
module dma_cmd_arbiter #(
    parameter int ADDR_WD    = 32,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CH_WD      = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]         ch_cmd_valid,
    input  logic [NUM_CH*ADDR_WD-1:0] ch_cmd_src_addr,
    input  logic [NUM_CH*ADDR_WD-1:0] ch_cmd_dst_addr,
    input  logic [NUM_CH*2-1:0]       ch_cmd_burst,
    input  logic [NUM_CH*ADDR_WD-1:0] ch_cmd_len,
    input  logic [NUM_CH*3-1:0]       ch_cmd_size,
    output logic [NUM_CH-1:0]         ch_cmd_ready,
    output logic [NUM_CH-1:0]         ch_done,
    output logic                    cmd_valid,
    output logic [ADDR_WD-1:0]      cmd_src_addr,
    output logic [ADDR_WD-1:0]      cmd_dst_addr,
    output logic [1:0]              cmd_burst,
    output logic [ADDR_WD-1:0]      cmd_len,
    output logic [2:0]              cmd_size,
    input  logic                    cmd_ready,
    input  logic                    xfer_done,
    output logic                    busy,
    output logic [CH_WD-1:0]        active_ch
);

    localparam int ENTRY_W = 3*ADDR_WD + 5;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t               state, next_state;
    logic [CH_WD-1:0]     rr_ptr;
    logic [CH_WD-1:0]     grant_ch;
    logic                 grant_found;
    logic                 pop_en;
    logic [NUM_CH-1:0]    fifo_empty;
    logic [ENTRY_W-1:0]   fifo_head [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_fifo
        logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0]   wr_ptr;
        logic [PTR_W-1:0]   rd_ptr;
        logic [CNT_W-1:0]   count;
        logic               push;
        logic               pop;

        assign push = ch_cmd_valid[i] & ch_cmd_ready[i];
        assign pop  = pop_en & (grant_ch == CH_WD'(i));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end

        // Storage is data only; validity is tracked entirely by the pointers and count.
        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr] <= {ch_cmd_src_addr[i*ADDR_WD +: ADDR_WD],
                                ch_cmd_dst_addr[i*ADDR_WD +: ADDR_WD],
                                ch_cmd_burst[i*2 +: 2],
                                ch_cmd_len[i*ADDR_WD +: ADDR_WD],
                                ch_cmd_size[i*3 +: 3]};
            end
        end

        assign fifo_head[i]    = mem[rd_ptr];
        assign fifo_empty[i]   = (count == '0);
        assign ch_cmd_ready[i] = (count != CNT_W'(FIFO_DEPTH));
    end

    // Search starts one past the last winner so every channel gets a turn.
    always_comb begin
        int               idx;
        logic [CH_WD-1:0] cand;
        grant_found = 1'b0;
        grant_ch    = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx  = (int'(rr_ptr) + k) % NUM_CH;
            cand = CH_WD'(idx);
            if (!grant_found && !fifo_empty[cand]) begin
                grant_found = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop_en     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    pop_en     = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE:     if (cmd_ready) next_state = WAIT_DONE;
            WAIT_DONE: if (xfer_done) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr       <= CH_WD'(NUM_CH - 1);
            active_ch    <= '0;
            cmd_src_addr <= '0;
            cmd_dst_addr <= '0;
            cmd_burst    <= '0;
            cmd_len      <= '0;
            cmd_size     <= '0;
            ch_done      <= '0;
        end else begin
            if (pop_en) begin
                rr_ptr    <= grant_ch;
                active_ch <= grant_ch;
                {cmd_src_addr, cmd_dst_addr, cmd_burst, cmd_len, cmd_size} <= fifo_head[grant_ch];
            end
            // Completion outside WAIT_DONE is not tied to any command, so it is dropped.
            if (state == WAIT_DONE && xfer_done) ch_done <= NUM_CH'(1) << active_ch;
            else                                 ch_done <= '0;
        end
    end

    assign cmd_valid = (state == ISSUE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dma_cmd_arbiter.sv
// Scoreboard bench for dma_cmd_arbiter: expected issues and done pulses are queued
// by each scenario task and checked by a monitor as the DUT produces them.
module tb_dma_cmd_arbiter;

    localparam int AW  = 32;
    localparam int NCH = 4;

    typedef struct packed {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [1:0]    burst;
        logic [AW-1:0] len;
        logic [2:0]    size;
    } cmd_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [NCH-1:0]      ch_cmd_valid;
    logic [NCH*AW-1:0]   ch_cmd_src_addr;
    logic [NCH*AW-1:0]   ch_cmd_dst_addr;
    logic [NCH*2-1:0]    ch_cmd_burst;
    logic [NCH*AW-1:0]   ch_cmd_len;
    logic [NCH*3-1:0]    ch_cmd_size;
    logic [NCH-1:0]      ch_cmd_ready;
    logic [NCH-1:0]      ch_done;
    logic                cmd_valid;
    logic [AW-1:0]       cmd_src_addr;
    logic [AW-1:0]       cmd_dst_addr;
    logic [1:0]          cmd_burst;
    logic [AW-1:0]       cmd_len;
    logic [2:0]          cmd_size;
    logic                cmd_ready;
    logic                xfer_done;
    logic                busy;
    logic [1:0]          active_ch;

    int checks   = 0;
    int failures = 0;
    int mon_issue_cnt = 0;
    int mon_done_cnt  = 0;

    cmd_t           exp_q [$];
    logic [NCH-1:0] done_q [$];
    cmd_t           mon_got;
    cmd_t           mon_exp;
    logic [NCH-1:0] mon_dexp;

    always #5 clk = ~clk;

    dma_cmd_arbiter #(.ADDR_WD(AW), .NUM_CH(NCH), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .ch_cmd_valid(ch_cmd_valid), .ch_cmd_src_addr(ch_cmd_src_addr),
        .ch_cmd_dst_addr(ch_cmd_dst_addr), .ch_cmd_burst(ch_cmd_burst),
        .ch_cmd_len(ch_cmd_len), .ch_cmd_size(ch_cmd_size),
        .ch_cmd_ready(ch_cmd_ready), .ch_done(ch_done),
        .cmd_valid(cmd_valid), .cmd_src_addr(cmd_src_addr),
        .cmd_dst_addr(cmd_dst_addr), .cmd_burst(cmd_burst),
        .cmd_len(cmd_len), .cmd_size(cmd_size),
        .cmd_ready(cmd_ready), .xfer_done(xfer_done),
        .busy(busy), .active_ch(active_ch)
    );

    // Monitor: a handshake seen mid-cycle completes at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            if (cmd_valid && cmd_ready) begin
                mon_got = {cmd_src_addr, cmd_dst_addr, cmd_burst, cmd_len, cmd_size};
                mon_issue_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL issue_unexpected: got %h, required no issue", mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        failures++;
                        $display("FAIL issue_fields: got %h, required %h", mon_got, mon_exp);
                    end
                end
            end
            if (ch_done !== '0) begin
                mon_done_cnt++;
                checks++;
                if (done_q.size() == 0) begin
                    failures++;
                    $display("FAIL done_unexpected: got %b, required none", ch_done);
                end else begin
                    mon_dexp = done_q.pop_front();
                    if (ch_done !== mon_dexp) begin
                        failures++;
                        $display("FAIL done_channel: got %b, required %b", ch_done, mon_dexp);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic cmd_t mk(input logic [AW-1:0] s, input logic [AW-1:0] d,
                                input logic [1:0] b, input logic [AW-1:0] l,
                                input logic [2:0] z);
        cmd_t c;
        c.src = s; c.dst = d; c.burst = b; c.len = l; c.size = z;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int ch, input cmd_t c);
        ch_cmd_src_addr[ch*AW +: AW] = c.src;
        ch_cmd_dst_addr[ch*AW +: AW] = c.dst;
        ch_cmd_burst[ch*2 +: 2]      = c.burst;
        ch_cmd_len[ch*AW +: AW]      = c.len;
        ch_cmd_size[ch*3 +: 3]       = c.size;
    endtask

    task automatic push(input int ch, input cmd_t c, output bit acc);
        set_cmd(ch, c);
        acc = ch_cmd_ready[ch];
        ch_cmd_valid     = '0;
        ch_cmd_valid[ch] = 1'b1;
        tick();
        ch_cmd_valid = '0;
    endtask

    // Controller model: accepts immediately, completes three edges after acceptance.
    task automatic run_ctrl(input int n_done);
        int  start;
        int  wait_cnt;
        bit  acc;
        start    = mon_done_cnt;
        wait_cnt = 0;
        cmd_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && mon_done_cnt < start + n_done; cyc++) begin
            xfer_done = (wait_cnt == 1);
            acc = cmd_valid && cmd_ready;
            tick();
            if (acc) wait_cnt = 3;
            else if (wait_cnt > 0) wait_cnt--;
        end
        cmd_ready = 1'b0;
        xfer_done = 1'b0;
        checks++;
        if (mon_done_cnt < start + n_done) begin
            failures++;
            $display("FAIL ctrl_timeout: got %0d dones, required %0d", mon_done_cnt - start, n_done);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ch_cmd_valid = '0;
        cmd_ready = 1'b0;
        xfer_done = 1'b0;
        exp_q.delete();
        done_q.delete();
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drained: got %0d issues/%0d dones pending, required 0/0",
                     name, exp_q.size(), done_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ch_cmd_valid = '0;
        ch_cmd_src_addr = '0; ch_cmd_dst_addr = '0; ch_cmd_len = '0;
        ch_cmd_burst = '0; ch_cmd_size = '0;
        cmd_ready = 1'b0;
        xfer_done = 1'b0;
        tick();
        tick();
        checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL rst_cmd_valid: got %b, required 0", cmd_valid); end
        checks++; if ({cmd_src_addr, cmd_dst_addr, cmd_burst, cmd_len, cmd_size} !== '0) begin
            failures++; $display("FAIL rst_cmd_fields: got %h, required 0", {cmd_src_addr, cmd_dst_addr, cmd_len}); end
        checks++; if (ch_done !== 4'b0) begin failures++; $display("FAIL rst_ch_done: got %b, required 0000", ch_done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b, required 0", busy); end
        checks++; if (active_ch !== 2'd0) begin failures++; $display("FAIL rst_active_ch: got %0d, required 0", active_ch); end
        checks++; if (ch_cmd_ready !== 4'hF) begin failures++; $display("FAIL rst_ready: got %b, required 1111", ch_cmd_ready); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        cmd_t c;
        bit   acc;
        do_reset();
        c = mk(32'h100, 32'h200, 2'd1, 32'd7, 3'd2);
        exp_q.push_back(c);
        done_q.push_back(4'b0100);
        push(2, c, acc);
        checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid: got %b, required 0", cmd_valid); end
        tick();
        checks++; if (cmd_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b, required 1", cmd_valid); end
        checks++; if ({cmd_src_addr, cmd_dst_addr, cmd_burst, cmd_len, cmd_size} !== c) begin
            failures++; $display("FAIL single_fields: got %h, required %h", {cmd_src_addr, cmd_dst_addr, cmd_burst, cmd_len, cmd_size}, c); end
        checks++; if (active_ch !== 2'd2 || busy !== 1'b1) begin
            failures++; $display("FAIL single_active: got ch=%0d busy=%b, required ch=2 busy=1", active_ch, busy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (cmd_valid !== 1'b1 || {cmd_src_addr, cmd_dst_addr, cmd_burst, cmd_len, cmd_size} !== c) begin
                failures++; $display("FAIL single_stall_%0d: got valid=%b len=%0d, required valid=1 len=7", i, cmd_valid, cmd_len);
            end
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        checks++; if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL single_accept: got valid=%b busy=%b, required valid=0 busy=1", cmd_valid, busy); end
        tick();
        tick();
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        checks++; if (ch_done !== 4'b0100 || busy !== 1'b0) begin
            failures++; $display("FAIL single_done: got done=%b busy=%b, required done=0100 busy=0", ch_done, busy); end
        tick();
        checks++; if (ch_done !== 4'b0 || cmd_src_addr !== 32'h100) begin
            failures++; $display("FAIL single_after: got done=%b src=%h, required done=0000 src=100", ch_done, cmd_src_addr); end
        check_drained("single");
    endtask

    task automatic test_fairness();
        cmd_t c;
        bit   acc;
        int   base;
        do_reset();
        base = mon_issue_cnt;
        for (int r = 0; r < 2; r++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                c = mk(32'h1000 + 32'(ch*16 + r), 32'h2000 + 32'(ch), 2'd1, 32'(r + 1), 3'd3);
                exp_q.push_back(c);
                done_q.push_back(4'(1 << ch));
                push(ch, c, acc);
                checks++; if (acc !== 1'b1) begin failures++; $display("FAIL fair_push_%0d_%0d: got ready=%b, required 1", r, ch, acc); end
            end
        end
        run_ctrl(8);
        checks++; if (mon_issue_cnt - base != 8) begin
            failures++; $display("FAIL fair_issue_count: got %0d, required 8", mon_issue_cnt - base); end
        check_drained("fair");
    endtask

    task automatic test_full();
        cmd_t c;
        bit   acc;
        do_reset();
        c = mk(32'h300, 32'h400, 2'd1, 32'd0, 3'd2);
        exp_q.push_back(c);
        done_q.push_back(4'b0010);
        push(1, c, acc);
        tick();
        for (int l = 1; l <= 4; l++) begin
            c = mk(32'h300 + 32'(l), 32'h400, 2'd1, 32'(l), 3'd2);
            exp_q.push_back(c);
            done_q.push_back(4'b0010);
            push(1, c, acc);
            checks++; if (acc !== 1'b1) begin failures++; $display("FAIL full_push_%0d: got ready=%b, required 1", l, acc); end
        end
        checks++; if (ch_cmd_ready[1] !== 1'b0) begin failures++; $display("FAIL full_ready_low: got %b, required 0", ch_cmd_ready[1]); end
        c = mk(32'h305, 32'h400, 2'd1, 32'd5, 3'd2);
        push(1, c, acc);
        checks++; if (acc !== 1'b0) begin failures++; $display("FAIL full_fifth_push: got ready=%b, required 0", acc); end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        checks++; if (ch_cmd_ready[1] !== 1'b0) begin failures++; $display("FAIL full_ready_before_pop: got %b, required 0", ch_cmd_ready[1]); end
        tick();
        checks++; if (ch_cmd_ready[1] !== 1'b1 || cmd_len !== 32'd1) begin
            failures++; $display("FAIL full_after_pop: got ready=%b len=%0d, required ready=1 len=1", ch_cmd_ready[1], cmd_len); end
        run_ctrl(4);
        tick();
        tick();
        checks++; if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL full_no_extra: got valid=%b busy=%b, required 0/0", cmd_valid, busy); end
        check_drained("full");
    endtask

    task automatic test_spurious_done();
        cmd_t c;
        bit   acc;
        do_reset();
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        checks++; if (ch_done !== 4'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL spur_idle: got done=%b busy=%b, required 0000/0", ch_done, busy); end
        c = mk(32'h500, 32'h600, 2'd2, 32'd3, 3'd1);
        exp_q.push_back(c);
        done_q.push_back(4'b1000);
        push(3, c, acc);
        tick();
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        checks++; if (ch_done !== 4'b0 || cmd_valid !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL spur_issue: got done=%b valid=%b, required 0000/1", ch_done, cmd_valid); end
        run_ctrl(1);
        checks++; if (active_ch !== 2'd3 || busy !== 1'b0) begin
            failures++; $display("FAIL spur_hold_active: got ch=%0d busy=%b, required 3/0", active_ch, busy); end
        check_drained("spur");
    endtask

    task automatic test_reset_mid();
        cmd_t c;
        bit   acc;
        do_reset();
        c = mk(32'h700, 32'h800, 2'd1, 32'd9, 3'd2);
        exp_q.push_back(c);
        push(1, c, acc);
        tick();
        push(2, mk(32'h701, 32'h801, 2'd1, 32'd1, 3'd2), acc);
        push(3, mk(32'h702, 32'h802, 2'd1, 32'd2, 3'd2), acc);
        push(1, mk(32'h703, 32'h803, 2'd1, 32'd3, 3'd2), acc);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        checks++; if (busy !== 1'b1 || cmd_valid !== 1'b0) begin
            failures++; $display("FAIL mid_wait: got busy=%b valid=%b, required 1/0", busy, cmd_valid); end
        rst = 1'b0;
        #1;
        checks++; if (cmd_valid !== 1'b0 || busy !== 1'b0 || active_ch !== 2'd0 || ch_cmd_ready !== 4'hF || cmd_len !== '0) begin
            failures++; $display("FAIL mid_async: got valid=%b busy=%b ch=%0d ready=%b len=%0d, required 0/0/0/1111/0",
                                 cmd_valid, busy, active_ch, ch_cmd_ready, cmd_len); end
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        checks++; if (ch_done !== 4'b0) begin failures++; $display("FAIL mid_no_done: got %b, required 0000", ch_done); end
        rst = 1'b1;
        tick();
        tick();
        checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL mid_flushed: got valid=%b, required 0", cmd_valid); end
        c = mk(32'h900, 32'hA00, 2'd0, 32'd4, 3'd0);
        set_cmd(3, c);
        set_cmd(0, mk(32'h910, 32'hA10, 2'd0, 32'd5, 3'd0));
        exp_q.push_back(mk(32'h910, 32'hA10, 2'd0, 32'd5, 3'd0));
        exp_q.push_back(c);
        done_q.push_back(4'b0001);
        done_q.push_back(4'b1000);
        ch_cmd_valid = 4'b1001;
        tick();
        ch_cmd_valid = '0;
        tick();
        checks++; if (active_ch !== 2'd0) begin failures++; $display("FAIL mid_first_grant: got %0d, required 0", active_ch); end
        run_ctrl(2);
        check_drained("mid");
    endtask

    task automatic test_back_to_back();
        cmd_t c;
        bit   acc;
        do_reset();
        c = mk(32'hB00, 32'hC00, 2'd1, 32'd10, 3'd2);
        exp_q.push_back(c);
        push(0, c, acc);
        tick();
        c = mk(32'hB01, 32'hC01, 2'd1, 32'd11, 3'd2);
        exp_q.push_back(c);
        push(1, c, acc);
        c = mk(32'hB02, 32'hC02, 2'd1, 32'd12, 3'd2);
        exp_q.push_back(c);
        push(2, c, acc);
        done_q.push_back(4'b0001);
        done_q.push_back(4'b0010);
        done_q.push_back(4'b0100);
        done_q.push_back(4'b0001);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        c = mk(32'hB03, 32'hC03, 2'd1, 32'd13, 3'd2);
        exp_q.push_back(c);
        push(0, c, acc);
        checks++; if (acc !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL b2b_push_wait: got ready=%b busy=%b, required 1/1", acc, busy); end
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        checks++; if (ch_done !== 4'b0001 || cmd_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_done: got done=%b valid=%b, required 0001/0", ch_done, cmd_valid); end
        tick();
        checks++; if (cmd_valid !== 1'b1 || active_ch !== 2'd1) begin
            failures++; $display("FAIL b2b_regrant: got valid=%b ch=%0d, required 1/1", cmd_valid, active_ch); end
        run_ctrl(3);
        check_drained("b2b");
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_full();
        test_spurious_done();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
